// File: rtl/fibonacci_random_decoder_pkg.sv
// Shared widths, state encoding and weight seeds for the Fibonacci
// encode/decode blocks.
package fib_pkg;

  localparam int FIB_W = 32;
  localparam int BIN_W = 16;
  localparam int ACC_W = 24;
  localparam int WGT_W = 22;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // F(2) and F(3): the weights of bit 0 and bit 1.
  localparam logic [WGT_W-1:0] WGT_INIT0 = WGT_W'(1);
  localparam logic [WGT_W-1:0] WGT_INIT1 = WGT_W'(2);

endpackage

// File: rtl/fibonacci_random_decoder_if.sv
// Begin/done handshake and data bus between a requester and the
// Fibonacci decoder.
interface fibonacci_random_decoder_if;
  import fib_pkg::*;

  logic             begin_f_b;
  logic [FIB_W-1:0] input_fib;
  logic [BIN_W-1:0] output_bin;
  logic             overflow;
  logic             busy;
  logic             convert_done;

  modport master (
    output begin_f_b,
    output input_fib,
    input  output_bin,
    input  overflow,
    input  busy,
    input  convert_done
  );

  modport slave (
    input  begin_f_b,
    input  input_fib,
    output output_bin,
    output overflow,
    output busy,
    output convert_done
  );

endinterface

// File: rtl/fibonacci_random_decoder_weight_gen.sv
// Running Fibonacci weight pair (w_cur, w_nxt); load reseeds to (1, 2),
// step advances one position.
module fibonacci_weight_gen
  import fib_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WGT_W-1:0] w_cur
);

  logic [WGT_W-1:0] w_cur_q, w_cur_d;
  logic [WGT_W-1:0] w_nxt_q, w_nxt_d;

  // The final step leaves F(34) in w_nxt, which wraps; it is never consumed.
  always_comb begin
    w_cur_d = w_cur_q;
    w_nxt_d = w_nxt_q;
    if (load) begin
      w_cur_d = WGT_INIT0;
      w_nxt_d = WGT_INIT1;
    end else if (step) begin
      w_cur_d = w_nxt_q;
      w_nxt_d = w_cur_q + w_nxt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cur_q <= WGT_INIT0;
      w_nxt_q <= WGT_INIT1;
    end else begin
      w_cur_q <= w_cur_d;
      w_nxt_q <= w_nxt_d;
    end
  end

  assign w_cur = w_cur_q;

endmodule

// File: rtl/fibonacci_random_decoder.sv
// Fibonacci-weighted code word to binary converter; walks all FIB_W bits
// LSB first, one per clock, so latency is fixed regardless of content.
module fibonacci_random_decoder
  import fib_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  fibonacci_random_decoder_if.slave   bus
);

  localparam int               IDX_W    = $clog2(FIB_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FIB_W - 1);
  localparam logic [ACC_W-1:0] BIN_MAX  = {{(ACC_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};

  logic [1:0]       state_q, state_d;
  logic [FIB_W-1:0] sr_q, sr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BIN_W-1:0] out_bin_q, out_bin_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             wgt_load;
  logic             wgt_step;
  logic [WGT_W-1:0] w_cur;
  logic [ACC_W-1:0] acc_add;

  fibonacci_weight_gen u_weight_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (wgt_load),
    .step  (wgt_step),
    .w_cur (w_cur)
  );

  assign acc_add = acc_q + (sr_q[0] ? {{(ACC_W-WGT_W){1'b0}}, w_cur} : '0);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    out_bin_d = out_bin_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wgt_load  = 1'b0;
    wgt_step  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // A start seen in the DONE cycle gives back-to-back conversions.
        if (bus.begin_f_b) begin
          sr_d     = bus.input_fib;
          acc_d    = '0;
          idx_d    = '0;
          wgt_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_add;
        sr_d     = sr_q >> 1;
        wgt_step = 1'b1;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          out_bin_d = acc_add[BIN_W-1:0];
          ovf_d     = (acc_add > BIN_MAX);
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_bin_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out_bin_q <= out_bin_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.output_bin   = out_bin_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = busy_q;
  assign bus.convert_done = done_q;

endmodule

// File: tb/tb_fibonacci_random_decoder.sv
// Directed vector bench for the Fibonacci decoder: table of code words with
// hand-computed sums, plus protocol and mid-run reset sequences.
module tb_fibonacci_random_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fibonacci_random_decoder_if dec_if ();

  fibonacci_random_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (dec_if)
  );

  typedef struct {
    logic [31:0] fib;
    logic [15:0] bin;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present a word with begin high for one start edge; returns #1 after E0.
  task automatic start(input logic [31:0] word);
    @(negedge clk);
    dec_if.begin_f_b = 1'b1;
    dec_if.input_fib = word;
    @(posedge clk);
    #1;
    dec_if.begin_f_b = 1'b0;
  endtask

  // Count edges until convert_done is seen; returns #1 after that edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dec_if.convert_done) break;
      if (cyc >= 40) begin
        $display("FAIL done_timeout: no convert_done within %0d cycles", cyc);
        n_total++;
        break;
      end
    end
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{32'h0000_0000, 16'h0000, 1'b0};
    vecs[1]  = '{32'h0000_0001, 16'd1,    1'b0};
    vecs[2]  = '{32'h0000_0003, 16'd3,    1'b0};
    vecs[3]  = '{32'h0000_0004, 16'd3,    1'b0};
    vecs[4]  = '{32'h0000_0005, 16'd4,    1'b0};
    vecs[5]  = '{32'h0000_000F, 16'd11,   1'b0};
    vecs[6]  = '{32'h0020_0000, 16'h6FF1, 1'b0};
    vecs[7]  = '{32'h0040_0000, 16'hB520, 1'b0};
    vecs[8]  = '{32'h0080_0000, 16'h2511, 1'b1};
    vecs[9]  = '{32'h0060_0000, 16'h2511, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 16'hCCC7, 1'b1};

    dec_if.begin_f_b = 1'b0;
    dec_if.input_fib = '0;

    #12;
    check("reset_bin",  32'(dec_if.output_bin),   32'h0);
    check("reset_ovf",  32'(dec_if.overflow),     32'h0);
    check("reset_busy", 32'(dec_if.busy),         32'h0);
    check("reset_done", 32'(dec_if.convert_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      start(vecs[i].fib);
      check($sformatf("v%0d_busy", i), 32'(dec_if.busy), 32'h1);
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'd32);
      check($sformatf("v%0d_bin", i), 32'(dec_if.output_bin), 32'(vecs[i].bin));
      check($sformatf("v%0d_ovf", i), 32'(dec_if.overflow), 32'(vecs[i].ovf));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(dec_if.convert_done), 32'h0);
      $display("vec %0d: fib=0x%08h bin=0x%04h ovf=%0d latency=%0d",
               i, vecs[i].fib, dec_if.output_bin, dec_if.overflow, cyc);
    end

    // begin held high through BUSY, input changed mid-run: latched word wins.
    @(negedge clk);
    dec_if.begin_f_b = 1'b1;
    dec_if.input_fib = 32'h0000_0003;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    dec_if.input_fib = 32'hFFFF_FFFF;
    wait_done(cyc);
    dec_if.begin_f_b = 1'b0;
    check("hold_latency", 32'(cyc), 32'd27);
    check("hold_bin", 32'(dec_if.output_bin), 32'd3);
    check("hold_ovf", 32'(dec_if.overflow), 32'h0);
    begin
      int extra = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (dec_if.convert_done) extra++;
      end
      check("hold_single_result", 32'(extra), 32'h0);
    end
    $display("hold: bin=0x%04h busy=%0d", dec_if.output_bin, dec_if.busy);

    // Back-to-back: restart requested in the DONE cycle.
    start(32'h0000_0005);
    wait_done(cyc);
    check("b2b_first_bin", 32'(dec_if.output_bin), 32'd4);
    dec_if.begin_f_b = 1'b1;
    dec_if.input_fib = 32'h0000_0004;
    @(posedge clk);
    #1;
    dec_if.begin_f_b = 1'b0;
    check("b2b_busy", 32'(dec_if.busy), 32'h1);
    check("b2b_bin_held", 32'(dec_if.output_bin), 32'd4);
    wait_done(cyc);
    check("b2b_spacing", 32'(cyc + 1), 32'd33);
    check("b2b_second_bin", 32'(dec_if.output_bin), 32'd3);
    $display("b2b: second bin=0x%04h spacing=%0d", dec_if.output_bin, cyc + 1);

    // Asynchronous reset at cycle 10 of BUSY discards the conversion.
    start(32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_bin",  32'(dec_if.output_bin),   32'h0);
    check("arst_ovf",  32'(dec_if.overflow),     32'h0);
    check("arst_busy", 32'(dec_if.busy),         32'h0);
    check("arst_done", 32'(dec_if.convert_done), 32'h0);
    begin
      int seen = 0;
      repeat (3) begin
        @(posedge clk);
        #1;
        if (dec_if.convert_done) seen++;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (dec_if.convert_done) seen++;
      end
      check("arst_no_done", 32'(seen), 32'h0);
      check("arst_idle", 32'(dec_if.busy), 32'h0);
    end
    start(32'h0000_000F);
    wait_done(cyc);
    check("arst_restart_latency", 32'(cyc), 32'd32);
    check("arst_restart_bin", 32'(dec_if.output_bin), 32'd11);
    $display("arst: restart bin=0x%04h latency=%0d", dec_if.output_bin, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
